// File: rtl/servo_preset_sequencer_pkg.sv
// Shared definitions for the servo preset sequencer: FSM state encoding and default widths.
package servo_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    MANUAL = 2'b01,
    AUTO   = 2'b10
  } seq_state_e;

  localparam int DEF_DUTY_W   = 8;
  localparam int DEF_N_PRESET = 8;
  localparam int IDX_W        = $clog2(DEF_N_PRESET);

endpackage

// File: rtl/servo_preset_sequencer_dwell_timer.sv
// Dwell timer: counts 0..DWELL_CYCLES-1 while enabled, pulses tc on the terminal count, clear wins.
module seq_dwell_timer #(
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/servo_preset_sequencer.sv
// Preset table sequencer feeding the X/Y PWM duty codes; new duties commit only on frame_start.
// Optional macro SEQ_PINGPONG_EN: AUTO bounces 0..N-1..0 instead of wrapping upward.
module servo_preset_sequencer
  import servo_seq_pkg::*;
#(
  parameter int DUTY_W       = DEF_DUTY_W,
  parameter int N_PRESET     = DEF_N_PRESET,
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic                        sysclk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        btn_next,
  input  logic                        btn_prev,
  input  logic                        btn_auto,
  input  logic                        wr_en,
  input  logic [$clog2(N_PRESET)-1:0] wr_addr,
  input  logic [DUTY_W-1:0]           wr_x,
  input  logic [DUTY_W-1:0]           wr_y,
  input  logic                        frame_start,
  output logic [DUTY_W-1:0]           duty_x,
  output logic [DUTY_W-1:0]           duty_y,
  output logic                        duty_upd,
  output logic [$clog2(N_PRESET)-1:0] preset_idx,
  output logic                        auto_active
);

  localparam int IW = $clog2(N_PRESET);

  seq_state_e        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              pend_q, pend_d;
  logic              next_q, prev_q, auto_q;
  logic [DUTY_W-1:0] dx_q, dy_q;
  logic              upd_q;
  logic [DUTY_W-1:0] tab_x_q [N_PRESET];
  logic [DUTY_W-1:0] tab_y_q [N_PRESET];

  logic rise_n, rise_p, rise_a;
  logic active, step_n, step_p, in_auto;
  logic dwell_clr, dwell_tc, wr_hit, commit;

`ifdef SEQ_PINGPONG_EN
  logic dir_q, dir_d;  // 1 = counting up
`endif

  assign rise_n  = btn_next && !next_q;
  assign rise_p  = btn_prev && !prev_q;
  assign rise_a  = btn_auto && !auto_q;
  assign active  = enable && (state_q != IDLE);
  assign step_n  = active && rise_n && !rise_p;
  assign step_p  = active && rise_p && !rise_n;
  assign in_auto = active && (state_q == AUTO);
  // Leaving AUTO or any manual step restarts the dwell from zero.
  assign dwell_clr = !in_auto || step_n || step_p;
  assign wr_hit    = wr_en && (wr_addr == idx_q);
  assign commit    = frame_start && pend_q && (state_q != IDLE);

  seq_dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .clr_i (dwell_clr),
    .en_i  (in_auto),
    .tc_o  (dwell_tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
`ifdef SEQ_PINGPONG_EN
    dir_d   = dir_q;
`endif
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = MANUAL;
        MANUAL:  if (rise_a) state_d = AUTO;
        AUTO:    if (rise_a) state_d = MANUAL;
        default: state_d = IDLE;
      endcase
    end

    if (step_n) begin
      idx_d = idx_q + IW'(1);
    end else if (step_p) begin
      idx_d = idx_q - IW'(1);
    end else if (dwell_tc) begin
`ifdef SEQ_PINGPONG_EN
      if (dir_q) begin
        if (idx_q == IW'(N_PRESET - 1)) begin
          idx_d = idx_q - IW'(1);
          dir_d = 1'b0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        if (idx_q == '0) begin
          idx_d = idx_q + IW'(1);
          dir_d = 1'b1;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
`else
      idx_d = idx_q + IW'(1);
`endif
    end

    // A fresh change outranks a commit, so a change landing on a frame waits for the next one.
    pend_d = pend_q;
    if (!enable)
      pend_d = 1'b0;
    else if ((idx_d != idx_q) || wr_hit)
      pend_d = 1'b1;
    else if (commit)
      pend_d = 1'b0;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      next_q  <= 1'b0;
      prev_q  <= 1'b0;
      auto_q  <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      next_q  <= btn_next;
      prev_q  <= btn_prev;
      auto_q  <= btn_auto;
      upd_q   <= commit;
      if (commit) begin
        dx_q <= tab_x_q[idx_q];
        dy_q <= tab_y_q[idx_q];
      end
    end
  end

`ifdef SEQ_PINGPONG_EN
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n)
      dir_q <= 1'b1;
    else
      dir_q <= dir_d;
  end
`endif

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PRESET; i++) begin
        tab_x_q[i] <= '0;
        tab_y_q[i] <= '0;
      end
    end else if (wr_en) begin
      tab_x_q[wr_addr] <= wr_x;
      tab_y_q[wr_addr] <= wr_y;
    end
  end

  assign duty_x      = dx_q;
  assign duty_y      = dy_q;
  assign duty_upd    = upd_q;
  assign preset_idx  = idx_q;
  assign auto_active = (state_q == AUTO);

endmodule
